// File: rtl/dense_classifier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dense_classifier_pkg
// Description : Shared CNN parameter package: fixed-point format, FSM state
//               encoding and saturation-bound helpers for the dense layer.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dense_classifier_pkg;

  localparam int c_WORD_SIZE   = 32;
  localparam int c_LENGTH_SIZE = 10;
  localparam int c_ADR_SIZE    = 4;
  localparam int c_FRAC_BITS   = 16;

  // Widest intermediate the helpers support (2*WORD_SIZE must fit).
  localparam int c_SAT_CALC_W  = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Largest value representable in a signed word of width w.
  function automatic logic signed [c_SAT_CALC_W-1:0] sat_hi(input int w);
    logic signed [c_SAT_CALC_W-1:0] v;
    v = '0;
    for (int i = 0; i < c_SAT_CALC_W; i++) begin
      if (i < w - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Smallest value representable in a signed word of width w.
  function automatic logic signed [c_SAT_CALC_W-1:0] sat_lo(input int w);
    return ~sat_hi(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_mul_sat.sv
`default_nettype none
// ============================================================================
// Module      : fixed_mul_sat
// Description : Combinational signed fixed-point multiply, arithmetic shift
//               right by FRAC_BITS, and clamp to the signed word range.
// Ports       : i_a, i_b  - signed operands (WORD_SIZE)
//               o_y       - saturated result (WORD_SIZE)
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_mul_sat
  import dense_classifier_pkg::*;
#(
  parameter int WORD_SIZE = c_WORD_SIZE,
  parameter int FRAC_BITS = c_FRAC_BITS
) (
  input  logic [WORD_SIZE-1:0] i_a,
  input  logic [WORD_SIZE-1:0] i_b,
  output logic [WORD_SIZE-1:0] o_y
);

  localparam int c_PW = 2 * WORD_SIZE;
  localparam logic signed [c_PW-1:0] c_HI = c_PW'(sat_hi(WORD_SIZE));
  localparam logic signed [c_PW-1:0] c_LO = c_PW'(sat_lo(WORD_SIZE));

  logic signed [c_PW-1:0] w_a;
  logic signed [c_PW-1:0] w_b;
  logic signed [c_PW-1:0] w_prod;
  logic signed [c_PW-1:0] w_shift;

  // Sign-extend first so the double-width product is exact.
  assign w_a     = {{WORD_SIZE{i_a[WORD_SIZE-1]}}, i_a};
  assign w_b     = {{WORD_SIZE{i_b[WORD_SIZE-1]}}, i_b};
  assign w_prod  = w_a * w_b;
  assign w_shift = w_prod >>> FRAC_BITS;

  always_comb begin
    o_y = w_shift[WORD_SIZE-1:0];
    if (w_shift > c_HI) begin
      o_y = c_HI[WORD_SIZE-1:0];
    end else if (w_shift < c_LO) begin
      o_y = c_LO[WORD_SIZE-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dense_classifier.sv
`default_nettype none
// ============================================================================
// Module      : dense_classifier
// Description : Single-feature dense layer with argmax. Walks an external
//               combinational weight LUT, emits one saturated score per
//               neuron and reports the winning class and its score.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               start, featureIn      - request and signed feature
//               ready                 - high in IDLE
//               lutAdr, lutData       - weight LUT address / returned weight
//               neuronValid/Idx/Out   - per-neuron score stream
//               done                  - one-cycle completion pulse
//               classOut, scoreOut    - argmax result, held
// Revision    : 1.0 - initial release
// ============================================================================
module dense_classifier
  import dense_classifier_pkg::*;
#(
  parameter int WORD_SIZE   = c_WORD_SIZE,
  parameter int LENGTH_SIZE = c_LENGTH_SIZE,
  parameter int ADR_SIZE    = c_ADR_SIZE,
  parameter int FRAC_BITS   = c_FRAC_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] featureIn,
  output logic                 ready,
  output logic [ADR_SIZE-1:0]  lutAdr,
  input  logic [WORD_SIZE-1:0] lutData,
  output logic                 neuronValid,
  output logic [ADR_SIZE-1:0]  neuronIdx,
  output logic [WORD_SIZE-1:0] neuronOut,
  output logic                 done,
  output logic [ADR_SIZE-1:0]  classOut,
  output logic [WORD_SIZE-1:0] scoreOut
);

  localparam logic [ADR_SIZE-1:0] c_LAST = ADR_SIZE'(LENGTH_SIZE - 1);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [ADR_SIZE-1:0]         r_cnt;
  logic [WORD_SIZE-1:0]        r_feat;
  logic signed [WORD_SIZE-1:0] r_max;
  logic [ADR_SIZE-1:0]         r_arg;
  logic                        r_nvalid;
  logic [ADR_SIZE-1:0]         r_nidx;
  logic signed [WORD_SIZE-1:0] r_nout;
  logic [ADR_SIZE-1:0]         r_class;
  logic [WORD_SIZE-1:0]        r_score;
  logic [WORD_SIZE-1:0]        w_prod_sat;
  logic                        w_take;

  fixed_mul_sat #(
    .WORD_SIZE(WORD_SIZE),
    .FRAC_BITS(FRAC_BITS)
  ) u_mul (
    .i_a(r_feat),
    .i_b(lutData),
    .o_y(w_prod_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    done        = 1'b0;
    lutAdr      = '0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        lutAdr = r_cnt;
        if (r_cnt == c_LAST) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: w_state_nxt = ST_DONE;
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Index 0 always seeds the running max; later neurons must be strictly
  // greater, so ties keep the lower index.
  assign w_take = r_nvalid && ((r_nidx == '0) || (r_nout > r_max));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_feat   <= '0;
      r_max    <= '0;
      r_arg    <= '0;
      r_nvalid <= 1'b0;
      r_nidx   <= '0;
      r_nout   <= '0;
      r_class  <= '0;
      r_score  <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_feat <= featureIn;
        r_cnt  <= '0;
      end else if (r_state == ST_RUN) begin
        r_cnt <= r_cnt + 1'b1;
      end

      r_nvalid <= (r_state == ST_RUN);
      if (r_state == ST_RUN) begin
        r_nidx <= r_cnt;
        r_nout <= w_prod_sat;
      end

      if (w_take) begin
        r_max <= r_nout;
        r_arg <= r_nidx;
      end

      // The last neuron is still in the compare stage during FLUSH, so the
      // result is taken from the compare outcome rather than the registers.
      if (r_state == ST_FLUSH) begin
        r_class <= w_take ? r_nidx : r_arg;
        r_score <= w_take ? r_nout : r_max;
      end
    end
  end

  assign neuronValid = r_nvalid;
  assign neuronIdx   = r_nidx;
  assign neuronOut   = r_nout;
  assign classOut    = r_class;
  assign scoreOut    = r_score;

endmodule
`default_nettype wire

// File: doc/dense_classifier.md
DENSE_CLASSIFIER -- requirements
Module: dense_classifier

Interface
REQ-001 Parameter WORD_SIZE, default 32: width of the feature, the weight, the per-neuron score and the final score (signed two's complement).
REQ-002 Parameter LENGTH_SIZE, default 10: number of output neurons (classes) and number of weight LUT entries.
REQ-003 Parameter ADR_SIZE, default 4: width of the weight LUT address and the class index.
REQ-004 Parameter FRAC_BITS, default 16: fractional bits of the fixed-point format shared by feature and weight.
REQ-005 One clock and one reset: reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 start  input  1  request to classify featureIn; sampled only while ready=1.
REQ-009 featureIn  input  WORD_SIZE  signed feature; captured on an accepted start.
REQ-010 ready  output  1  high only in IDLE.
REQ-011 lutAdr  output  ADR_SIZE  address driven to the combinational weight LUT.
REQ-012 lutData  input  WORD_SIZE  signed weight returned by the LUT in the same cycle as lutAdr.
REQ-013 neuronValid  output  1  per-neuron score strobe.
REQ-014 neuronIdx  output  ADR_SIZE  index of the score on neuronOut.
REQ-015 neuronOut  output  WORD_SIZE  saturated per-neuron score.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 classOut  output  ADR_SIZE  argmax class; held until the next accepted start or reset.
REQ-018 scoreOut  output  WORD_SIZE  maximum score; held like classOut.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, FLUSH and DONE.
REQ-020 In IDLE, start=1 SHALL latch featureIn into featReg, clear cnt to 0 and move to RUN.
REQ-021 In RUN, lutAdr SHALL equal cnt and cnt SHALL increment each cycle; when cnt==LENGTH_SIZE-1 the FSM moves to FLUSH.
REQ-022 In IDLE, FLUSH and DONE, lutAdr SHALL be 0.
REQ-023 Each RUN cycle SHALL register prod = sat((featReg*lutData) >>> FRAC_BITS): full 2*WORD_SIZE signed product, arithmetic shift, clamped to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1]. neuronOut, neuronIdx=cnt and neuronValid=1 are visible in the next cycle.
REQ-024 The compare stage SHALL update maxReg/argReg when neuronValid=1 and (neuronIdx==0 or neuronOut > maxReg, signed strict); ties keep the lower index.
REQ-025 FLUSH SHALL last exactly one cycle, then move to DONE; DONE SHALL last one cycle with done=1, then move to IDLE.
REQ-026 classOut/scoreOut SHALL be copied from argReg/maxReg at entry to DONE.
REQ-027 Latency: a start accepted at the edge ending cycle 0 gives neuronValid in cycles 2..LENGTH_SIZE+1 (idx 0..LENGTH_SIZE-1) and done in cycle LENGTH_SIZE+2 (12 for the defaults).
REQ-028 start while ready=0 SHALL be ignored, and featureIn changes during RUN SHALL have no effect.
REQ-029 start in the DONE cycle SHALL be ignored; the next request is accepted in IDLE one cycle later.

Reset
REQ-030 rst=1 SHALL force IDLE and zero cnt, featReg, maxReg, argReg, lutAdr, neuronValid, neuronIdx, neuronOut, done, classOut and scoreOut; ready=1 in the first cycle after rst deasserts.
REQ-031 rst during RUN/FLUSH/DONE SHALL abort: no done pulse and no further neuronValid until a new start.

Structure
REQ-032 The FSM state encoding, FRAC_BITS and the saturation bounds SHALL live in the shared CNN parameter package.
REQ-033 The multiply-shift-saturate datapath SHALL be a sub-module fixed_mul_sat (combinational); the FSM, counter and compare stage stay in dense_classifier.
REQ-034 The weight LUT is external and is connected through lutAdr and lutData only.

Verification (defaults; bench LUT w[j]=(j-4)*0x10000)
REQ-035 featureIn=0x00010000, start pulse -> neuronOut idx0..9 = 0xFFFC0000..0x00050000; done in cycle 12; classOut=9; scoreOut=0x00050000.
REQ-036 featureIn=0xFFFF0000 (-1.0) -> classOut=0, scoreOut=0x00040000.
REQ-037 All weights 0x00010000 and featureIn=0x00020000 -> all scores 0x00020000 (tie); classOut=0.
REQ-038 featureIn=0x7FFFFFFF and all weights 0x7FFFFFFF -> every neuronOut=0x7FFFFFFF (saturated); with all weights 0x80000000 -> every neuronOut=0x80000000.
REQ-039 start held high for 20 cycles -> exactly one done in cycle 12 and a second accepted start in cycle 13 (done in cycle 25); featureIn changed in cycle 5 -> results unchanged.
REQ-040 rst in cycle 5 of a run -> no done; ready=1 and classOut=0, scoreOut=0 in cycle 6; a new run then completes normally.
